// File: rtl/mio_bus_arbiter.sv
// CPU/aux memory-IO bus arbiter: round-robin grant, RAM/IO decode, fixed RAM latency, IO ack wait.
// Optional IO wait-state timeout with sticky bus_err, enabled by defining BUS_TIMEOUT_EN.
module mio_bus_arbiter #(
    parameter int         ADDR_W  = 12,
    parameter int         RAM_LAT = 2,
    parameter logic [3:0] IO_NIB  = 4'hF,
    parameter int         TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    input  logic              aux_req,
    input  logic [31:0]       aux_addr,
    output logic [31:0]       aux_rdata,
    output logic              aux_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack,
    output logic              bus_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        IO_WAIT  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    if (RAM_LAT < 1 || RAM_LAT > 15 || TIMEOUT < 1) begin : g_param_check
        $error("mio_bus_arbiter: RAM_LAT must be 1..15 and TIMEOUT at least 1");
    end

    state_t      state_q;
    state_t      state_d;
    logic        gnt_q;
    logic        last_grant_q;
    logic        we_q;
    logic        ram_first_q;
    logic [3:0]  lat_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] aux_rdata_q;

    logic        grant_cpu;
    logic        grant_aux;
    logic        grant_any;
    logic        cpu_is_io;
    logic        accept;
    logic        ram_last;
    logic        timeout_hit;

    // Round-robin: on a tie the master that did not win last time is granted.
    always_comb begin
        grant_cpu = cpu_req && (!aux_req || (last_grant_q == M_AUX));
        grant_aux = aux_req && !grant_cpu;
        grant_any = grant_cpu || grant_aux;
        cpu_is_io = (cpu_addr[31:28] == IO_NIB);
        accept    = (state_q == IDLE) && grant_any;
    end

    // The strobe cycle is not counted; the counter then runs RAM_LAT..1 and data is taken at 1.
    assign ram_last = (state_q == RAM_WAIT) && !ram_first_q && (lat_cnt_q == 4'd1);

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            bus_err_q;

    // io_ack in the final allowed cycle wins over the timeout.
    assign timeout_hit = (state_q == IO_WAIT) && !io_ack && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q != IO_WAIT) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (timeout_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = (grant_cpu && cpu_is_io) ? IO_WAIT : RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (ram_last) begin
                    state_d = DONE;
                end
            end
            IO_WAIT: begin
                if (io_ack || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_en    = (state_q == RAM_WAIT) && ram_first_q;
        ram_we    = ram_en && we_q;
        io_rd     = (state_q == IO_WAIT) && !we_q;
        io_wr     = (state_q == IO_WAIT) && we_q;
        cpu_ready = (state_q == DONE) && (gnt_q == M_CPU);
        aux_ready = (state_q == DONE) && (gnt_q == M_AUX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q        <= M_CPU;
            last_grant_q <= M_AUX;
            ram_first_q  <= 1'b0;
            lat_cnt_q    <= '0;
        end else if (accept) begin
            gnt_q        <= grant_aux;
            last_grant_q <= grant_aux;
            ram_first_q  <= 1'b1;
            lat_cnt_q    <= 4'(RAM_LAT);
        end else if (state_q == RAM_WAIT) begin
            if (ram_first_q) begin
                ram_first_q <= 1'b0;
            end else begin
                lat_cnt_q <= lat_cnt_q - 4'd1;
            end
        end
    end

    // Request capture; aux is always a RAM read.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= grant_cpu ? cpu_addr : aux_addr;
            we_q    <= grant_cpu && cpu_we;
            wdata_q <= grant_cpu ? cpu_wdata : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else if (ram_last && !we_q) begin
            if (gnt_q == M_CPU) begin
                cpu_rdata_q <= ram_rdata;
            end else begin
                aux_rdata_q <= ram_rdata;
            end
        end else if ((state_q == IO_WAIT) && !we_q) begin
            if (io_ack) begin
                cpu_rdata_q <= io_rdata;
            end else if (timeout_hit) begin
                cpu_rdata_q <= 32'hDEADBEEF;
            end
        end
    end

    assign ram_addr  = addr_q[ADDR_W+1:2];
    assign ram_wdata = wdata_q;
    assign io_addr   = addr_q;
    assign io_wdata  = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign aux_rdata = aux_rdata_q;
    assign state     = state_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter: table of CPU accesses plus aux, round-robin, reset and idle-ack sequences.
module tb_mio_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        aux_req;
    logic [31:0] aux_addr, aux_rdata;
    logic        aux_ready;
    logic        ram_en, ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        io_rd, io_wr;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_ack;
    logic        bus_err;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    mio_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .aux_req(aux_req), .aux_addr(aux_addr), .aux_rdata(aux_rdata), .aux_ready(aux_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    // RAM model: two-cycle read latency, contents 0x0C000000 | word address, junk outside the data cycle.
    logic        pipe_vld = 1'b0;
    logic [31:0] pipe_data = 32'h0;
    always @(posedge clk) begin
        pipe_vld  <= ram_en && !ram_we;
        pipe_data <= 32'h0C000000 | {20'd0, ram_addr};
        ram_rdata <= pipe_vld ? pipe_data : 32'h0BAD0BAD;
    end

    typedef struct packed {
        logic        is_io;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;
        logic [31:0] io_data;
        logic [31:0] exp_ram_addr;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic is_io, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ack_dly, input logic [31:0] io_data,
                                input logic [31:0] exp_ram_addr, input logic [31:0] exp_rdata,
                                input int exp_lat);
        vec_t v;
        v.is_io = is_io; v.we = we; v.addr = addr; v.wdata = wdata; v.ack_dly = ack_dly;
        v.io_data = io_data; v.exp_ram_addr = exp_ram_addr; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cpu(input vec_t v, input int idx);
        int lat, rdy, en_n, io_n, tail, aux_n;
        logic [31:0] en_addr, en_wd, io_a, io_wd;
        logic en_we, io_w;
        lat = 0; rdy = 0; en_n = 0; io_n = 0; tail = 0; aux_n = 0;
        en_addr = 0; en_wd = 0; io_a = 0; io_wd = 0; en_we = 0; io_w = 0;
        cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
        for (int i = 1; i <= 40 && tail < 3; i++) begin
            @(posedge clk); #1;
            io_ack = 1'b0;
            if (lat != 0) tail++;
            if (ram_en) begin
                en_n++; en_addr = {20'd0, ram_addr}; en_we = ram_we; en_wd = ram_wdata;
            end
            if (io_rd || io_wr) begin
                io_n++; io_a = io_addr; io_wd = io_wdata; io_w = io_wr;
                if (io_n == v.ack_dly) begin
                    io_ack = 1'b1; io_rdata = v.io_data;
                end
            end
            if (cpu_ready) begin
                rdy++;
                if (lat == 0) lat = i;
                cpu_req = 1'b0;
            end
            if (aux_ready) aux_n++;
        end
        cpu_req = 1'b0; io_ack = 1'b0;
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d cpu_ready pulses", idx), rdy, 1);
        check($sformatf("v%0d aux_ready pulses", idx), aux_n, 0);
        check($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.exp_rdata);
        if (v.is_io) begin
            check($sformatf("v%0d io strobe cycles", idx), io_n, v.ack_dly);
            check($sformatf("v%0d io_addr", idx), io_a, v.addr);
            check($sformatf("v%0d io_wr", idx), io_w, v.we);
            check($sformatf("v%0d ram_en cycles", idx), en_n, 0);
            if (v.we) check($sformatf("v%0d io_wdata", idx), io_wd, v.wdata);
        end else begin
            check($sformatf("v%0d ram_en cycles", idx), en_n, 1);
            check($sformatf("v%0d ram_addr", idx), en_addr, v.exp_ram_addr);
            check($sformatf("v%0d ram_we", idx), en_we, v.we);
            check($sformatf("v%0d io strobe cycles", idx), io_n, 0);
            if (v.we) check($sformatf("v%0d ram_wdata", idx), en_wd, v.wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [3];
        int n, both, cpu_n, aux_n, lat;

        vecs[0] = mk(0, 0, 32'h00000014, 32'h0,        0, 32'h0,        32'h005, 32'h0C000005, 4);
        vecs[1] = mk(0, 1, 32'h00000008, 32'h00001234, 0, 32'h0,        32'h002, 32'h0C000005, 4);
        vecs[2] = mk(1, 0, 32'hF0000000, 32'h0,        3, 32'hA5A5A5A5, 32'h0,   32'hA5A5A5A5, 4);
        vecs[3] = mk(1, 1, 32'hF0000010, 32'hCAFE0001, 1, 32'h11111111, 32'h0,   32'hA5A5A5A5, 2);
        vecs[4] = mk(0, 0, 32'hE0003FFC, 32'h0,        0, 32'h0,        32'hFFF, 32'h0C000FFF, 4);
        vecs[5] = mk(1, 0, 32'hF0000004, 32'h0,        1, 32'h5A5A0001, 32'h0,   32'h5A5A0001, 2);
        vecs[6] = mk(0, 0, 32'h00004000, 32'h0,        0, 32'h0,        32'h000, 32'h0C000000, 4);
        vecs[7] = mk(0, 1, 32'hEFFFFFF0, 32'h0F0F0F0F, 0, 32'h0,        32'hFFC, 32'h0C000000, 4);

        reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        aux_req = 0; aux_addr = 0; io_rdata = 0; io_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", state, 0);
        check("reset strobes", {ram_en, ram_we, io_rd, io_wr}, 0);
        check("reset readies", {cpu_ready, aux_ready}, 0);
        check("reset bus_err", bus_err, 0);
        check("reset cpu_rdata", cpu_rdata, 0);
        check("reset aux_rdata", aux_rdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < NVEC; k++) begin
            run_cpu(vecs[k], k);
            @(posedge clk); #1;
        end

        // Aux alone: RAM read routed to aux only.
        aux_addr = 32'h00000040; aux_req = 1'b1;
        lat = 0; cpu_n = 0; aux_n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (aux_ready) begin
                aux_n++;
                if (lat == 0) lat = i;
                aux_req = 1'b0;
            end
            if (cpu_ready) cpu_n++;
        end
        aux_req = 1'b0;
        check("aux latency", lat, 4);
        check("aux ready pulses", aux_n, 1);
        check("aux cpu_ready leak", cpu_n, 0);
        check("aux rdata", aux_rdata, 32'h0C000010);
        check("aux cpu_rdata kept", cpu_rdata, 32'h0C000000);

        // Both held: round-robin order CPU, AUX, CPU.
        order[0] = 2; order[1] = 2; order[2] = 2;
        n = 0; both = 0;
        cpu_we = 1'b0; cpu_addr = 32'h00000100; aux_addr = 32'h00000200;
        cpu_req = 1'b1; aux_req = 1'b1;
        for (int i = 1; i <= 60 && n < 3; i++) begin
            @(posedge clk); #1;
            if (cpu_ready && aux_ready) both++;
            if (cpu_ready) begin order[n] = 0; n++; end
            else if (aux_ready) begin order[n] = 1; n++; end
        end
        cpu_req = 1'b0; aux_req = 1'b0;
        cpu_n = 0; aux_n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (cpu_ready) cpu_n++;
            if (aux_ready) aux_n++;
        end
        check("rr grant count", n, 3);
        check("rr grant 0", order[0], 0);
        check("rr grant 1", order[1], 1);
        check("rr grant 2", order[2], 0);
        check("rr double ready", both, 0);
        check("rr trailing readies", cpu_n + aux_n, 0);
        check("rr cpu_rdata", cpu_rdata, 32'h0C000040);
        check("rr aux_rdata", aux_rdata, 32'h0C000080);

        // io_ack while idle is ignored.
        io_rdata = 32'h77777777; io_ack = 1'b1;
        cpu_n = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (cpu_ready || state != 2'd0) cpu_n++;
        end
        io_ack = 1'b0;
        check("idle io_ack ignored", cpu_n, 0);
        check("idle io_ack rdata", cpu_rdata, 32'h0C000040);

        // Reset while in RAM_WAIT aborts without a ready pulse.
        cpu_we = 1'b0; cpu_addr = 32'h00000020; cpu_req = 1'b1;
        @(posedge clk); #1;
        check("abort first cycle state", state, 1);
        check("abort ram_en", ram_en, 1);
        @(posedge clk); #1;
        check("abort wait state", state, 1);
        reset = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        check("abort state", state, 0);
        check("abort strobes", {ram_en, ram_we, io_rd, io_wr}, 0);
        check("abort readies", {cpu_ready, aux_ready}, 0);
        check("abort cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;
        cpu_n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (cpu_ready || aux_ready) cpu_n++;
        end
        check("abort no ready later", cpu_n, 0);
        check("abort idle after", state, 0);

`ifdef BUS_TIMEOUT_EN
        cpu_we = 1'b0; cpu_addr = 32'hF0000008; cpu_req = 1'b1;
        n = 0; cpu_n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (io_rd) n++;
            if (cpu_ready) begin cpu_n++; cpu_req = 1'b0; end
        end
        cpu_req = 1'b0;
        check("timeout io_rd cycles", n, 16);
        check("timeout ready pulses", cpu_n, 1);
        check("timeout rdata", cpu_rdata, 32'hDEADBEEF);
        check("timeout bus_err", bus_err, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("timeout bus_err cleared", bus_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
